// File: rtl/div_pkg.sv
// Shared defines for the iterative divider.
// Holds the FSM state type, the default width and handshake constants.
package div_pkg;

    localparam int N_REG = 32;

    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;
    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } div_state_e;

endpackage

// File: rtl/div.sv
// Iterative restoring divider for DIV/DIVU, one quotient bit per cycle.
// Result is {remainder, quotient}, held while the EX stage keeps i_start high.
module div
    import div_pkg::*;
#(
    parameter int N_DIV = N_REG
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_signed,
    input  logic [N_DIV-1:0]   i_op_0,
    input  logic [N_DIV-1:0]   i_op_1,
    input  logic               i_start,
    input  logic               i_annul,
    output logic [2*N_DIV-1:0] o_result,
    output logic               o_ready
);

    localparam logic [5:0]       CNT_LAST = 6'(N_DIV);
    localparam logic [N_DIV-1:0] ONE_N    = {{(N_DIV-1){1'b0}}, 1'b1};

    div_state_e         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*N_DIV:0]   rem_q, rem_d;
    logic [N_DIV-1:0]   dvs_q, dvs_d;
    logic               sgn_q, sgn_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*N_DIV-1:0] res_q, res_d;
    logic               rdy_q, rdy_d;

    logic               a_neg, b_neg;
    logic [N_DIV-1:0]   mag_a, mag_b;
    logic [2*N_DIV:0]   shf;
    logic [N_DIV+1:0]   diff;
    logic [2*N_DIV:0]   step;
    logic [N_DIV-1:0]   quo_mag, rem_mag;
    logic [N_DIV-1:0]   quo_fix, rem_fix;

    // operand magnitudes, computed from the live inputs at the latching edge
    assign a_neg = i_signed & i_op_0[N_DIV-1];
    assign b_neg = i_signed & i_op_1[N_DIV-1];
    assign mag_a = a_neg ? (~i_op_0 + ONE_N) : i_op_0;
    assign mag_b = b_neg ? (~i_op_1 + ONE_N) : i_op_1;

    // one restoring step: shift, trial subtract, keep if no borrow
    assign shf  = rem_q << 1;
    assign diff = {1'b0, shf[2*N_DIV:N_DIV]} - {2'b00, dvs_q};
    assign step = diff[N_DIV+1] ? shf
                                : {diff[N_DIV:0], shf[N_DIV-1:1], 1'b1};

    // sign fixup applied when the result is registered
    assign quo_mag = rem_q[N_DIV-1:0];
    assign rem_mag = rem_q[2*N_DIV-1:N_DIV];
    assign quo_fix = (sgn_q & neg_quo_q) ? (~quo_mag + ONE_N) : quo_mag;
    assign rem_fix = (sgn_q & neg_rem_q) ? (~rem_mag + ONE_N) : rem_mag;

    // next-state and datapath updates for the divider FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        sgn_d     = sgn_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        rdy_d     = rdy_q;
        unique case (state_q)
            IDLE: begin
                if (i_start == DIV_START && !i_annul) begin
                    sgn_d     = i_signed;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dvs_d     = mag_b;
                    rem_d     = {{(N_DIV+1){1'b0}}, mag_a};
                    cnt_d     = '0;
                    state_d   = (i_op_1 == '0) ? BY_ZERO : ON;
                end
            end
            BY_ZERO: begin
                // two-cycle wait keeps the zero answer at a fixed latency
                if (i_annul) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d = 6'd1;
                end else begin
                    res_d   = '0;
                    rdy_d   = DIV_READY;
                    state_d = END;
                end
            end
            ON: begin
                if (i_annul) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = {rem_fix, quo_fix};
                    rdy_d   = DIV_READY;
                    state_d = END;
                end else begin
                    rem_d = step;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            END: begin
                if (i_start == DIV_STOP) begin
                    res_d   = '0;
                    rdy_d   = DIV_NOT_READY;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, datapath and output registers with asynchronous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            sgn_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            rdy_q     <= DIV_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            sgn_q     <= sgn_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
            rdy_q     <= rdy_d;
        end
    end

    assign o_result = res_q;
    assign o_ready  = rdy_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the iterative divider.
// Driver pushes expected results; a monitor pops on each rising o_ready.
module tb_div;
    import div_pkg::*;

    typedef struct {
        logic [63:0] res;
        int          start;
        int          lat;
    } exp_t;

    logic        i_clk    = 1'b0;
    logic        i_rst_n  = 1'b0;
    logic        i_signed = 1'b0;
    logic [31:0] i_op_0   = '0;
    logic [31:0] i_op_1   = '0;
    logic        i_start  = 1'b0;
    logic        i_annul  = 1'b0;
    logic [63:0] o_result;
    logic        o_ready;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic rdy_prev = 1'b0;
    exp_t sb[$];

    div #(.N_DIV(32)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_signed (i_signed),
        .i_op_0   (i_op_0),
        .i_op_1   (i_op_1),
        .i_start  (i_start),
        .i_annul  (i_annul),
        .o_result (o_result),
        .o_ready  (o_ready)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: compare each new result against the oldest expectation
    always @(negedge i_clk) begin
        exp_t it;
        if (o_ready === 1'b1 && rdy_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 64'(o_ready), 64'(0));
            end else begin
                it = sb.pop_front();
                chk("result", o_result, it.res);
                chk("latency", 64'(cyc - it.start), 64'(it.lat));
            end
        end
        rdy_prev = o_ready;
    end

    // issue one division; called at a negedge
    task automatic do_op(input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input int lat,
                         input bit keep);
        exp_t e;
        int   n;
        e.res   = {er, eq};
        e.start = cyc + 1;
        e.lat   = lat;
        sb.push_back(e);
        i_signed = sg;
        i_op_0   = a;
        i_op_1   = b;
        i_start  = 1'b1;
        @(negedge i_clk);
        i_op_0   = $urandom;
        i_op_1   = $urandom;
        i_signed = ~sg;
        n = 0;
        while (o_ready !== 1'b1 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 100) begin
            chk("ready_timeout", 64'(o_ready), 64'(1));
            if (sb.size() > 0) void'(sb.pop_front());
        end
        repeat (2) @(negedge i_clk);
        chk("hold_ready", 64'(o_ready), 64'(1));
        chk("hold_result", o_result, {er, eq});
        if (!keep) begin
            i_start = 1'b0;
            @(negedge i_clk);
            chk("drop_ready", 64'(o_ready), 64'(0));
            chk("drop_result", o_result, 64'(0));
        end
    endtask

    // watch a window and count any o_ready assertion
    task automatic no_ready(input string nm, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge i_clk);
            if (o_ready !== 1'b0) seen++;
        end
        chk(nm, 64'(seen), 64'(0));
    endtask

    initial begin
        #1;
        chk("reset_ready", 64'(o_ready), 64'(0));
        chk("reset_result", o_result, 64'(0));
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
        do_op(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 2, 1'b0);
        do_op(1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 2, 1'b0);

        // annul mid-ON at cycle 10
        i_signed = 1'b0;
        i_op_0   = 32'd100;
        i_op_1   = 32'd7;
        i_start  = 1'b1;
        repeat (10) @(negedge i_clk);
        i_annul = 1'b1;
        i_start = 1'b0;
        @(negedge i_clk);
        i_annul = 1'b0;
        no_ready("annul_on_no_ready", 45);
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1,
              32'hFFFF_FFFF, 32'd0, 33, 1'b0);

        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h8000_0000, 32'd0, 33, 1'b0);
        do_op(1'b1, 32'd100, 32'hFFFF_FFF9,
              32'hFFFF_FFF2, 32'd2, 33, 1'b0);
        do_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
              32'd14, 32'hFFFF_FFFE, 33, 1'b0);
        do_op(1'b0, 32'd7, 32'd100, 32'd0, 32'd7, 33, 1'b0);
        do_op(1'b0, 32'hFFFF_FFF9, 32'd2,
              32'h7FFF_FFFC, 32'd1, 33, 1'b0);

        // annul while waiting in BY_ZERO
        i_op_0  = 32'd5;
        i_op_1  = 32'd0;
        i_start = 1'b1;
        @(negedge i_clk);
        i_annul = 1'b1;
        i_start = 1'b0;
        @(negedge i_clk);
        i_annul = 1'b0;
        no_ready("annul_bz_no_ready", 10);

        // start together with annul in IDLE is dropped
        i_op_0  = 32'd9;
        i_op_1  = 32'd3;
        i_start = 1'b1;
        i_annul = 1'b1;
        repeat (3) @(negedge i_clk);
        i_start = 1'b0;
        i_annul = 1'b0;
        no_ready("start_annul_idle", 40);
        do_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b0);

        // async reset at cycle 20 of ON
        i_signed = 1'b0;
        i_op_0   = 32'd100;
        i_op_1   = 32'd7;
        i_start  = 1'b1;
        repeat (21) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        i_start = 1'b0;
        #1;
        chk("rst_on_ready", 64'(o_ready), 64'(0));
        chk("rst_on_result", o_result, 64'(0));
        chk("rst_on_state", 64'(dut.state_q), 64'(IDLE));
        chk("rst_on_cnt", 64'(dut.cnt_q), 64'(0));
        chk("rst_on_rem", 64'(dut.rem_q), 64'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        no_ready("rst_on_no_ready", 40);
        do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1);

        // annul ignored in END, then async reset clears the held result
        i_annul = 1'b1;
        @(negedge i_clk);
        i_annul = 1'b0;
        chk("annul_end_ready", 64'(o_ready), 64'(1));
        chk("annul_end_result", o_result, {32'd2, 32'd14});
        #2 i_rst_n = 1'b0;
        i_start = 1'b0;
        #1;
        chk("rst_end_ready", 64'(o_ready), 64'(0));
        chk("rst_end_result", o_result, 64'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);

        repeat (3) @(negedge i_clk);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
